pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised successor to the core's single-register program counter.
- Holds the fetch PC and advances it by a fixed step each cycle.
- Supports stall, redirect from branch/jump resolution, and a small return-address stack (RAS) for call/return prediction.
- Sits at the front of the fetch stage and drives the instruction-memory address.

Parameters:
- WIDTH, 32: PC width in bits.
- STEP, 4: sequential increment in bytes; must be a power of two.
- RESET_VEC, 0: PC value after reset and while idle.
- RAS_DEPTH, 4: number of RAS entries; must be a power of two, at least 2.
- TRAP_VEC, 32'h0000_0100: misalignment trap target (used only with the optional feature).

Ports:
- clk_i, in, 1: clock. One clock; all state changes on its rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- start_i, in, 1: run enable; low holds the block in IDLE.
- stall_i, in, 1: hold the PC this cycle.
- redirect_i, in, 1: load redirect_pc_i.
- redirect_pc_i, in, WIDTH: redirect target.
- push_i, in, 1: call detected; push push_pc_i onto the RAS.
- push_pc_i, in, WIDTH: return address to push.
- pop_i, in, 1: return detected; load the RAS top into the PC.
- pc_o, out, WIDTH: current fetch PC, registered.
- valid_o, out, 1: pc_o is a live fetch address.
- ras_empty_o, out, 1: RAS count is 0.
- ras_underflow_o, out, 1: one-cycle pulse when pop_i is seen with the RAS empty.
- misalign_o, out, 1: one-cycle pulse on a misaligned redirect (optional feature only).

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - pc_o=RESET_VEC, valid_o=0, state IDLE.
  - RAS count=0, top pointer=0, ras_empty_o=1.
  - ras_underflow_o=0, misalign_o=0.
  - Reset overrides every other input, including mid-redirect or mid-push.
- States: IDLE, RUN.
  - IDLE: pc_o=RESET_VEC, valid_o=0; all other inputs ignored.
  - IDLE->RUN on a clock edge with start_i=1. The first RUN cycle presents RESET_VEC with valid_o=1; no increment happens on that edge.
  - RUN->IDLE on a clock edge with start_i=0. pc_o returns to RESET_VEC and the RAS is cleared.
- RUN next-PC priority, highest first:
  1. redirect_i: next PC = redirect_pc_i.
  2. pop_i with RAS non-empty: next PC = RAS top.
  3. stall_i: hold the PC.
  4. Otherwise: next PC = pc_o + STEP, modulo 2^WIDTH. All-ones-region wrap to 0 is legal and silent.
- Redirect and pop are taken even while stall_i=1; stall only suppresses the sequential increment.
- All updates appear on pc_o the cycle after the inputs are sampled (1-cycle latency).
- RAS update rules (circular buffer with top pointer):
  - push only: write push_pc_i at top+1, advance top, count+1 saturating at RAS_DEPTH. Push when full overwrites the oldest entry silently.
  - pop only, non-empty: top-1, count-1.
  - pop only, empty: no change to PC selection beyond rules 3/4; ras_underflow_o pulses for one cycle.
  - push and pop together: the PC takes the old top (if non-empty), then the top entry is replaced by push_pc_i; count unchanged. If empty, behaves as push plus an underflow pulse.
  - RAS updates follow push_i/pop_i regardless of redirect_i and stall_i.
- ras_empty_o is registered and reflects count after the edge.

Optional Feature:
- Macro: PC_GEN_ALIGN_CHECK_EN.
- Defined:
  - A redirect whose target has low log2(STEP) bits nonzero loads TRAP_VEC instead of the target.
  - misalign_o pulses for one cycle.
  - A RAS pop of a misaligned entry is treated the same way.
- Undefined:
  - Targets are used verbatim, with no alignment check.
  - misalign_o is tied to 0.

Test Plan:
- Reset then start_i=1, no other inputs (defaults) -> pc_o sequence 0x0, 0x0 (valid), 0x4, 0x8, 0xC; valid_o rises with the first valid 0x0.
- RUN at pc_o=0x10, stall_i=1 for 3 cycles together with redirect_i=1, redirect_pc_i=0x200 in the 2nd stall cycle -> pc_o 0x10, 0x10, 0x200, 0x200, then 0x204 after stall drops.
- Push 0x40, 0x80, 0xC0, 0x100, 0x140 (DEPTH=4), then 5 pops -> PC loads 0x140, 0x100, 0xC0, 0x80, then ras_underflow_o pulses and the PC increments sequentially.
- Same-cycle push_pc_i=0x300 and pop with top=0x80 -> next pc_o=0x80; following pop -> 0x300; count unchanged by the dual operation.
- pc_o=0xFFFF_FFFC, no stall -> next pc_o=0x0, no flags. Also assert rst_i mid-push: RAS empty, pc_o=RESET_VEC, valid_o=0.
- With PC_GEN_ALIGN_CHECK_EN, redirect to 0x202 -> pc_o=0x100, misalign_o=1 for one cycle. Without the macro -> pc_o=0x202, misalign_o=0.

Source files
------------

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Fetch program-counter generator with stall, redirect and a
//                small circular return-address stack (RAS) for call/return
//                prediction. Drives the instruction-memory fetch address.
//                Optional alignment check on redirect/pop targets is enabled
//                by defining the macro PC_GEN_ALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_pc_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             valid_o,
    output logic             ras_empty_o,
    output logic             ras_underflow_o,
    output logic             misalign_o
);

    localparam int               PTR_W    = $clog2(RAS_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
`ifdef PC_GEN_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_pc;
    logic             r_valid;
    logic             r_underflow;
    logic             r_misalign;
    logic             r_ras_empty;
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];

    logic [WIDTH-1:0] w_pc_nxt;
    logic             w_valid_nxt;
    logic             w_underflow_nxt;
    logic             w_misalign_nxt;
    logic [PTR_W-1:0] w_top_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_nonempty;
    logic             w_take;
    logic [WIDTH-1:0] w_target;
    logic             w_misaligned;

    // Non-sequential target: a redirect wins over a RAS pop.
    always_comb begin
        w_nonempty = (r_cnt != '0);
        w_take     = redirect_i || (pop_i && w_nonempty);
        w_target   = redirect_i ? redirect_pc_i : r_ras[r_top];
`ifdef PC_GEN_ALIGN_CHECK_EN
        w_misaligned = w_take && ((w_target & ALIGN_MASK) != '0);
`else
        w_misaligned = 1'b0;
`endif
    end

    // Next-state, next-PC and RAS control.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_valid_nxt     = r_valid;
        w_underflow_nxt = 1'b0;
        w_misalign_nxt  = 1'b0;
        w_top_nxt       = r_top;
        w_cnt_nxt       = r_cnt;
        w_wr_en         = 1'b0;
        w_wr_idx        = r_top;
        case (r_state)
            S_IDLE: begin
                // First RUN cycle presents RESET_VEC without incrementing.
                w_pc_nxt    = RESET_VEC;
                w_valid_nxt = 1'b0;
                if (start_i) begin
                    w_state_nxt = S_RUN;
                    w_valid_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (!start_i) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = RESET_VEC;
                    w_valid_nxt = 1'b0;
                    w_top_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_valid_nxt = 1'b1;
                    if (w_take) begin
                        w_pc_nxt       = w_misaligned ? TRAP_VEC : w_target;
                        w_misalign_nxt = w_misaligned;
                    end else if (!stall_i) begin
                        w_pc_nxt = r_pc + STEP_V;
                    end
                    // RAS bookkeeping is independent of redirect and stall.
                    if (push_i && pop_i && w_nonempty) begin
                        w_wr_en  = 1'b1;
                        w_wr_idx = r_top;
                    end else if (push_i) begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = r_top + PTR_W'(1);
                        w_top_nxt = r_top + PTR_W'(1);
                        w_cnt_nxt = (r_cnt == CNT_FULL) ? r_cnt : r_cnt + CNT_W'(1);
                    end else if (pop_i && w_nonempty) begin
                        w_top_nxt = r_top - PTR_W'(1);
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                    w_underflow_nxt = pop_i && !w_nonempty;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = RESET_VEC;
                w_valid_nxt = 1'b0;
                w_top_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, PC, flag and RAS pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_VEC;
            r_valid     <= 1'b0;
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
            r_ras_empty <= 1'b1;
            r_top       <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_valid     <= w_valid_nxt;
            r_underflow <= w_underflow_nxt;
            r_misalign  <= w_misalign_nxt;
            r_ras_empty <= (w_cnt_nxt == '0);
            r_top       <= w_top_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // RAS storage; contents beyond the live count are don't-care.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_wr_en) begin
            r_ras[w_wr_idx] <= push_pc_i;
        end
    end

    assign pc_o            = r_pc;
    assign valid_o         = r_valid;
    assign ras_empty_o     = r_ras_empty;
    assign ras_underflow_o = r_underflow;
    assign misalign_o      = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen: directed scenarios followed
//                by randomized traffic, checked against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst, start, stall, redirect, push, pop;
    logic [31:0] redirect_pc, push_pc;
    logic [31:0] pc;
    logic        valid, ras_empty, ras_underflow, misalign;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic        m_run, m_valid, m_under, m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_ras [$];

    pc_gen dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .stall_i         (stall),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .push_i          (push),
        .push_pc_i       (push_pc),
        .pop_i           (pop),
        .pc_o            (pc),
        .valid_o         (valid),
        .ras_empty_o     (ras_empty),
        .ras_underflow_o (ras_underflow),
        .misalign_o      (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Model of one clock edge, applied to the currently driven inputs.
    task automatic model_edge();
        logic [31:0] np;
        logic        nonempty, take;
        m_under = 1'b0;
        m_mis   = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_pc = 32'h0; m_valid = 1'b0; m_ras.delete();
        end else if (!m_run) begin
            m_pc = 32'h0; m_valid = start; m_run = start;
        end else if (!start) begin
            m_run = 1'b0; m_pc = 32'h0; m_valid = 1'b0; m_ras.delete();
        end else begin
            nonempty = (m_ras.size() != 0);
            take     = redirect || (pop && nonempty);
            if (redirect)               np = redirect_pc;
            else if (pop && nonempty)   np = m_ras[$];
            else if (stall)             np = m_pc;
            else                        np = m_pc + 32'd4;
`ifdef PC_GEN_ALIGN_CHECK_EN
            if (take && (np % 4 != 0)) begin
                np    = 32'h100;
                m_mis = 1'b1;
            end
`endif
            m_pc    = np;
            m_valid = 1'b1;
            if (pop && nonempty) void'(m_ras.pop_back());
            if (pop && !nonempty) m_under = 1'b1;
            if (push) begin
                m_ras.push_back(push_pc);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
        end
    endtask

    // Advance one cycle, then compare every output with the model.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("pc",        pc,            m_pc);
        check("valid",     32'(valid),    32'(m_valid));
        check("ras_empty", 32'(ras_empty),32'(m_ras.size() == 0));
        check("underflow", 32'(ras_underflow), 32'(m_under));
        check("misalign",  32'(misalign), 32'(m_mis));
    endtask

    task automatic idle_inputs();
        stall = 0; redirect = 0; push = 0; pop = 0;
        redirect_pc = 32'h0; push_pc = 32'h0;
    endtask

    initial begin
        rst = 1; start = 0;
        idle_inputs();
        m_run = 0; m_pc = 0; m_valid = 0; m_under = 0; m_mis = 0;
        #2;

        // Reset state
        step();
        check("reset_pc", pc, 32'h0);
        check("reset_empty", 32'(ras_empty), 32'h1);

        // Sequential fetch after start
        rst = 0;
        step();                              // still idle
        check("idle_valid", 32'(valid), 32'h0);
        start = 1;
        step(); check("first_pc", pc, 32'h0); check("first_valid", 32'(valid), 32'h1);
        step(); check("seq_4", pc, 32'h4);
        step(); check("seq_8", pc, 32'h8);
        step(); check("seq_c", pc, 32'hC);
        step(); check("seq_10", pc, 32'h10);

        // Stall with redirect inside the stall window
        stall = 1; step(); check("stall_hold", pc, 32'h10);
        redirect = 1; redirect_pc = 32'h200; step(); check("stall_redir", pc, 32'h200);
        redirect = 0; step(); check("stall_hold2", pc, 32'h200);
        stall = 0; step(); check("post_stall", pc, 32'h204);

        // Overfilled RAS, then drain past empty
        push = 1;
        for (int i = 1; i <= 5; i++) begin
            push_pc = 32'(i * 32'h40);
            step();
        end
        push = 0; pop = 1;
        step(); check("pop_140", pc, 32'h140);
        step(); check("pop_100", pc, 32'h100);
        step(); check("pop_c0",  pc, 32'hC0);
        step(); check("pop_80",  pc, 32'h80);
        step(); check("underflow_pulse", 32'(ras_underflow), 32'h1);
        check("underflow_seq", pc, 32'h84);
        pop = 0; step(); check("underflow_clear", 32'(ras_underflow), 32'h0);

        // Simultaneous push and pop
        push = 1; push_pc = 32'h40; step();
        push_pc = 32'h80; step();
        pop = 1; push_pc = 32'h300; step(); check("dual_pc", pc, 32'h80);
        push = 0; step(); check("dual_next", pc, 32'h300);
        step(); check("dual_bottom", pc, 32'h40);
        check("dual_empty", 32'(ras_empty), 32'h1);
        pop = 0;

        // Wrap at the top of the address space
        redirect = 1; redirect_pc = 32'hFFFF_FFFC; step();
        redirect = 0; step(); check("wrap_pc", pc, 32'h0);
        check("wrap_flags", {30'h0, ras_underflow, misalign}, 32'h0);

        // Misaligned redirect
        redirect = 1; redirect_pc = 32'h202; step();
`ifdef PC_GEN_ALIGN_CHECK_EN
        check("mis_pc", pc, 32'h100); check("mis_flag", 32'(misalign), 32'h1);
`else
        check("mis_pc", pc, 32'h202); check("mis_flag", 32'(misalign), 32'h0);
`endif
        redirect = 0; step(); check("mis_clear", 32'(misalign), 32'h0);

        // Reset in the middle of a push
        push = 1; push_pc = 32'h500; step();
        rst = 1; push_pc = 32'h600; step();
        check("rst_empty", 32'(ras_empty), 32'h1);
        check("rst_pc", pc, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        rst = 0; idle_inputs();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            start       = ($urandom_range(0, 19) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            push        = ($urandom_range(0, 3) == 0);
            push_pc     = $urandom & (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            pop         = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
